// File: rtl/ehgu_arb_pkg.sv
// Types and widths shared by the ehgu round-robin arbiter and its picker.
package ehgu_arb_pkg;

    import ehgu_basic_pkg::*;

    typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_REL} arb_state_t;

    localparam int ARB_CNT_W = $clog2(DP_WIDTH) + 1;

endpackage

// File: rtl/ehgu_basic_pkg.sv
// Shared ehgu datapath width and small arithmetic helpers used across ehgu blocks.
package ehgu_basic_pkg;

    localparam int DP_WIDTH = 8;
    localparam int DP_CNT_W = $clog2(DP_WIDTH) + 1;

    function automatic logic [DP_CNT_W-1:0] sum_of_ones(input logic [DP_WIDTH-1:0] vec);
        logic [DP_CNT_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < DP_WIDTH; i++) begin
            acc = acc + DP_CNT_W'(vec[i]);
        end
        return acc;
    endfunction

    // Extra bit keeps value+1 from wrapping before it is compared to the modulus.
    function automatic logic [DP_WIDTH-1:0] increment_modulo_unsigned(
        input logic [DP_WIDTH-1:0] value,
        input logic [DP_WIDTH-1:0] modulus
    );
        logic [DP_WIDTH:0] nxt;
        nxt = {1'b0, value} + (DP_WIDTH+1)'(1);
        if (nxt >= {1'b0, modulus}) begin
            return '0;
        end
        return nxt[DP_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/ehgu_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo NUM_REQ.
module ehgu_rr_pick #(
    parameter int NUM_REQ = 8,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               pick_valid,
    output logic [ID_W-1:0]    pick_id
);

    logic [2*NUM_REQ-1:0] doubled;
    logic [NUM_REQ-1:0]   rotated;
    logic [ID_W-1:0]      offset;
    logic [ID_W:0]        sum;

    // Doubling req makes the rotate a plain shift; a descending scan leaves the lowest set bit.
    always_comb begin
        doubled    = {req, req} >> ptr;
        rotated    = doubled[NUM_REQ-1:0];
        pick_valid = |rotated;
        offset     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = ID_W'(i);
            end
        end
        sum = {1'b0, offset} + {1'b0, ptr};
        if (sum >= (ID_W+1)'(NUM_REQ)) begin
            sum = sum - (ID_W+1)'(NUM_REQ);
        end
        pick_id = sum[ID_W-1:0];
    end

endmodule

// File: rtl/ehgu_rr_arbiter.sv
// Round-robin arbiter for the shared ehgu datapath: one-hot held grants with done/drop/timeout release.
module ehgu_rr_arbiter
    import ehgu_basic_pkg::*;
    import ehgu_arb_pkg::*;
#(
    parameter int NUM_REQ  = 8,
    parameter int MAX_HOLD = 16,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic                 done,
    output logic [NUM_REQ-1:0]   gnt,
    output logic                 gnt_valid,
    output logic [ID_W-1:0]      gnt_id,
    output logic [ARB_CNT_W-1:0] active_cnt,
    output logic                 timeout_pulse
);

    arb_state_t           state_q, state_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [DP_WIDTH-1:0]  hold_q, hold_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [ID_W-1:0]      gnt_id_q, gnt_id_d;
    logic                 timeout_q, timeout_d;
    logic [ARB_CNT_W-1:0] active_cnt_q;
    logic                 pick_valid;
    logic [ID_W-1:0]      pick_id;
    logic [ID_W-1:0]      ptr_after_owner;

    ehgu_rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_pick (
        .req       (req),
        .ptr       (ptr_q),
        .pick_valid(pick_valid),
        .pick_id   (pick_id)
    );

    assign ptr_after_owner = ID_W'(increment_modulo_unsigned(DP_WIDTH'(gnt_id_q), DP_WIDTH'(NUM_REQ)));

    // The pointer advances as the grant is released, so REL already arbitrates from the new position.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        gnt_d     = '0;
        gnt_id_d  = '0;
        timeout_d = 1'b0;
        case (state_q)
            ARB_IDLE, ARB_REL: begin
                if (pick_valid) begin
                    state_d  = ARB_BUSY;
                    gnt_id_d = pick_id;
                    gnt_d    = NUM_REQ'(1) << pick_id;
                    hold_d   = '0;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_BUSY: begin
                if (done || !req[gnt_id_q]) begin
                    state_d = ARB_REL;
                    ptr_d   = ptr_after_owner;
                end else if (hold_q == DP_WIDTH'(MAX_HOLD - 1)) begin
                    state_d   = ARB_REL;
                    ptr_d     = ptr_after_owner;
                    timeout_d = 1'b1;
                end else begin
                    gnt_d    = gnt_q;
                    gnt_id_d = gnt_id_q;
                    hold_d   = hold_q + DP_WIDTH'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            ptr_q        <= '0;
            hold_q       <= '0;
            gnt_q        <= '0;
            gnt_id_q     <= '0;
            timeout_q    <= 1'b0;
            active_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            hold_q       <= hold_d;
            gnt_q        <= gnt_d;
            gnt_id_q     <= gnt_id_d;
            timeout_q    <= timeout_d;
            active_cnt_q <= sum_of_ones(DP_WIDTH'(req));
        end
    end

    assign gnt           = gnt_q;
    assign gnt_valid     = (state_q == ARB_BUSY);
    assign gnt_id        = gnt_id_q;
    assign active_cnt    = active_cnt_q;
    assign timeout_pulse = timeout_q;

endmodule
